// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus generator and checker: walks every N_INPUTS vector in binary or Gray
// order, holds each for HOLD_CYCLES, and compares dut_out against exp_out at the end of the hold.
module truth_table_sweeper #(
    parameter int unsigned N_INPUTS    = 5,
    parameter int unsigned N_OUTPUTS   = 1,
    parameter int unsigned HOLD_CYCLES = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 mode_gray,
    output logic [N_INPUTS-1:0]  stim,
    input  logic [N_OUTPUTS-1:0] dut_out,
    input  logic [N_OUTPUTS-1:0] exp_out,
    output logic                 busy,
    output logic                 done,
    output logic [N_INPUTS:0]    mismatch_count,
    output logic                 fail_valid,
    output logic [N_INPUTS-1:0]  first_fail_vec
);

    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned CNT_W  = N_INPUTS + 1;

    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [N_INPUTS-1:0] IDX_LAST  = {N_INPUTS{1'b1}};

    // LOAD is the one-cycle gap between accepting start and driving vector 0
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]          state,      state_nxt;
    logic [N_INPUTS-1:0] idx,        idx_nxt;
    logic [HOLD_W-1:0]   hold,       hold_nxt;
    logic                gray_q,     gray_nxt;
    logic [N_INPUTS-1:0] stim_nxt;
    logic                busy_nxt;
    logic                done_nxt;
    logic [CNT_W-1:0]    count_nxt;
    logic                fail_valid_nxt;
    logic [N_INPUTS-1:0] first_fail_nxt;

    function automatic logic [N_INPUTS-1:0] to_vec(input logic [N_INPUTS-1:0] i, input logic g);
        return g ? (i ^ (i >> 1)) : i;
    endfunction

    // State and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            idx            <= '0;
            hold           <= '0;
            gray_q         <= 1'b0;
            stim           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            mismatch_count <= '0;
            fail_valid     <= 1'b0;
            first_fail_vec <= '0;
        end else begin
            state          <= state_nxt;
            idx            <= idx_nxt;
            hold           <= hold_nxt;
            gray_q         <= gray_nxt;
            stim           <= stim_nxt;
            busy           <= busy_nxt;
            done           <= done_nxt;
            mismatch_count <= count_nxt;
            fail_valid     <= fail_valid_nxt;
            first_fail_vec <= first_fail_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        hold_nxt       = hold;
        gray_nxt       = gray_q;
        stim_nxt       = stim;
        busy_nxt       = 1'b0;
        done_nxt       = done;
        count_nxt      = mismatch_count;
        fail_valid_nxt = fail_valid;
        first_fail_nxt = first_fail_vec;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt      = S_LOAD;
                    idx_nxt        = '0;
                    hold_nxt       = '0;
                    gray_nxt       = mode_gray;
                    done_nxt       = 1'b0;
                    count_nxt      = '0;
                    fail_valid_nxt = 1'b0;
                    first_fail_nxt = '0;
                end
            end
            S_LOAD: begin
                state_nxt = S_RUN;
                busy_nxt  = 1'b1;
                stim_nxt  = to_vec(idx, gray_q);
            end
            S_RUN: begin
                busy_nxt = 1'b1;
                if (hold == HOLD_LAST) begin
                    hold_nxt = '0;
                    if (dut_out != exp_out) begin
                        count_nxt = mismatch_count + 1'b1;
                        if (!fail_valid) begin
                            fail_valid_nxt = 1'b1;
                            first_fail_nxt = stim;
                        end
                    end
                    // Last vector has just been sampled; stim stays on it
                    if (idx == IDX_LAST) begin
                        state_nxt = S_DONE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        idx_nxt  = idx + 1'b1;
                        stim_nxt = to_vec(idx + 1'b1, gray_q);
                    end
                end else begin
                    hold_nxt = hold + 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized self-checking bench for truth_table_sweeper against a table-driven sweep model.
module tb_truth_table_sweeper;

    localparam int unsigned N   = 5;
    localparam int unsigned NO  = 4;
    localparam int unsigned H   = 10;
    localparam int unsigned V   = 32;
    localparam int unsigned TOT = V * H;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          mode_gray;
    logic [N-1:0]  stim;
    logic [NO-1:0] dut_out;
    logic [NO-1:0] exp_out;
    logic          busy;
    logic          done;
    logic [N:0]    mismatch_count;
    logic          fail_valid;
    logic [N-1:0]  first_fail_vec;

    logic [NO-1:0] dut_tab [V];
    logic [NO-1:0] exp_tab [V];

    // Small instance: 3 inputs, one-cycle hold, Gray order
    logic          s_start;
    logic          s_mode_gray;
    logic [2:0]    s_stim;
    logic          s_dut_out;
    logic          s_exp_out;
    logic          s_busy;
    logic          s_done;
    logic [3:0]    s_count;
    logic          s_fail_valid;
    logic [2:0]    s_first;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign dut_out   = dut_tab[stim];
    assign exp_out   = exp_tab[stim];
    assign s_dut_out = 1'b0;
    assign s_exp_out = (s_stim == 3'd5);

    truth_table_sweeper #(.N_INPUTS(N), .N_OUTPUTS(NO), .HOLD_CYCLES(H)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .mode_gray      (mode_gray),
        .stim           (stim),
        .dut_out        (dut_out),
        .exp_out        (exp_out),
        .busy           (busy),
        .done           (done),
        .mismatch_count (mismatch_count),
        .fail_valid     (fail_valid),
        .first_fail_vec (first_fail_vec)
    );

    truth_table_sweeper #(.N_INPUTS(3), .N_OUTPUTS(1), .HOLD_CYCLES(1)) u_small (
        .clk            (clk),
        .reset          (reset),
        .start          (s_start),
        .mode_gray      (s_mode_gray),
        .stim           (s_stim),
        .dut_out        (s_dut_out),
        .exp_out        (s_exp_out),
        .busy           (s_busy),
        .done           (s_done),
        .mismatch_count (s_count),
        .fail_valid     (s_fail_valid),
        .first_fail_vec (s_first)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic int vec_at(input int k, input bit g);
        return g ? (k ^ (k >> 1)) : k;
    endfunction

    // Reference: walk the sweep order over the response tables
    task automatic model(input bit g, output int cnt, output int first);
        cnt   = 0;
        first = -1;
        for (int k = 0; k < int'(V); k++) begin
            int v;
            v = vec_at(k, g);
            if (dut_tab[v] !== exp_tab[v]) begin
                cnt++;
                if (first < 0) first = v;
            end
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_stim"}, 32'(stim), 32'd0);
        check({tag, "_cnt"},  32'(mismatch_count), 32'd0);
        check({tag, "_fv"},   32'(fail_valid), 32'd0);
        check({tag, "_ffv"},  32'(first_fail_vec), 32'd0);
    endtask

    task automatic run_sweep(input string tag, input bit g, input bit poke);
        int ecnt;
        int efirst;
        model(g, ecnt, efirst);
        @(negedge clk);
        start     = 1'b1;
        mode_gray = g;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_start_done"}, 32'(done), 32'd0);
        check({tag, "_start_cnt"},  32'(mismatch_count), 32'd0);
        check({tag, "_start_fv"},   32'(fail_valid), 32'd0);
        for (int j = 0; j < int'(TOT); j++) begin
            @(negedge clk);
            if (poke && j == int'(TOT / 2)) begin
                start     = 1'b1;
                mode_gray = ~g;
            end else begin
                start = 1'b0;
            end
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_done_low"}, 32'(done), 32'd0);
            check({tag, "_stim"}, 32'(stim), 32'(vec_at(j / int'(H), g)));
        end
        @(negedge clk);
        check({tag, "_end_done"}, 32'(done), 32'd1);
        check({tag, "_end_busy"}, 32'(busy), 32'd0);
        check({tag, "_end_cnt"},  32'(mismatch_count), 32'(ecnt));
        check({tag, "_end_fv"},   32'(fail_valid), 32'(ecnt > 0));
        if (ecnt > 0) check({tag, "_end_ffv"}, 32'(first_fail_vec), 32'(efirst));
        check({tag, "_end_stim"}, 32'(stim), 32'(vec_at(int'(V) - 1, g)));
        repeat (3) @(negedge clk);
        check({tag, "_hold_done"}, 32'(done), 32'd1);
        check({tag, "_hold_cnt"},  32'(mismatch_count), 32'(ecnt));
    endtask

    task automatic run_small();
        logic [2:0] gseq [8];
        gseq = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
        @(negedge clk);
        s_start     = 1'b1;
        s_mode_gray = 1'b1;
        @(negedge clk);
        s_start     = 1'b0;
        s_mode_gray = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            check("small_stim", 32'(s_stim), 32'(gseq[j]));
            check("small_busy", 32'(s_busy), 32'd1);
            check("small_done_low", 32'(s_done), 32'd0);
        end
        @(negedge clk);
        check("small_done", 32'(s_done), 32'd1);
        check("small_cnt",  32'(s_count), 32'd1);
        check("small_fv",   32'(s_fail_valid), 32'd1);
        check("small_ffv",  32'(s_first), 32'd5);
    endtask

    initial begin
        logic [N-1:0] kv;
        reset       = 1'b1;
        start       = 1'b0;
        mode_gray   = 1'b0;
        s_start     = 1'b0;
        s_mode_gray = 1'b0;
        for (int k = 0; k < int'(V); k++) begin
            kv         = N'(k);
            dut_tab[k] = {NO{^kv}};
            exp_tab[k] = {NO{^kv}};
        end
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset = 1'b0;

        run_sweep("parity", 1'b0, 1'b0);

        for (int k = 0; k < int'(V); k++) begin
            kv         = N'(k);
            dut_tab[k] = '0;
            exp_tab[k] = NO'(&kv);
        end
        run_sweep("stuck0", 1'b0, 1'b0);

        for (int k = 0; k < int'(V); k++) begin
            dut_tab[k] = NO'($urandom);
            exp_tab[k] = ~dut_tab[k];
        end
        run_sweep("allfail", 1'b1, 1'b0);

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < int'(V); k++) begin
                dut_tab[k] = NO'($urandom);
                exp_tab[k] = dut_tab[k] ^ (($urandom_range(0, 3) == 0) ? NO'($urandom_range(1, 15)) : '0);
            end
            run_sweep("random", 1'($urandom_range(0, 1)), 1'b1);
        end

        // Abort in the middle of vector 7
        @(negedge clk);
        start     = 1'b1;
        mode_gray = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (7 * H + 2) @(negedge clk);
        check("pre_abort_stim", 32'(stim), 32'd7);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle("abort");
        @(negedge clk);
        check("abort_stays_idle", 32'(busy), 32'd0);

        for (int k = 0; k < int'(V); k++) begin
            kv         = N'(k);
            dut_tab[k] = {NO{^kv}};
            exp_tab[k] = {NO{^kv}};
        end
        run_sweep("after_abort", 1'b0, 1'b0);

        // Reset and start together: reset wins
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check_idle("rst_start");
        repeat (2) @(negedge clk);
        check("rst_start_no_run", 32'(busy), 32'd0);

        run_small();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
